vic_line_fetch: RTL and testbench

- Character-mode video fetch stage between the shared dual-port RAM read port (port B) and the VGA pixel generator.
- Once per scanline it reads screen codes, colour-RAM nibbles and character bitmap bytes for one text row slice, and stores them in a double-buffered line buffer.
- It then serves 4-bit palette indices to the pixel output path, indexed by horizontal pixel position.
- It owns the RAM port-B address bus; the CPU side (port A) is unaffected.

---
 rtl/vic_line_fetch_if.sv | 10 +
 rtl/vic_line_fetch.sv | 147 ++++++++++++++
 tb/tb_vic_line_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vic_line_fetch_if.sv
// RAM port-B read bus shared by the line fetch stage and the dual-port RAM.
//   mem_addr : 16-bit read address driven by the fetch stage
//   mem_data : 8-bit read data, valid one cycle after mem_addr (registered RAM)
interface vic_line_fetch_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;

  modport master (output mem_addr, input mem_data);
  modport slave  (input mem_addr, output mem_data);
endinterface

// File: rtl/vic_line_fetch.sv
// Character-mode line fetch: once per scanline reads screen codes, colour
// nibbles and glyph bytes into a double-buffered line buffer, then serves
// palette indices for the pixel path.
//   clk, reset_n     : pixel clock, async active-low reset
//   line_start       : swap banks and begin fetching line fetch_y
//   fetch_y          : active-area line to fetch
//   pix_active/pix_x : current pixel position inside the text window
//   bg_colour        : background palette index
//   border_colour    : border palette index
//   mem              : RAM port-B read bus (master side)
//   pix_colour       : registered palette index for the pixel
//   busy             : fetch in progress
//   overrun          : sticky, line_start arrived while busy
module vic_line_fetch #(
  parameter logic [15:0] SCREEN_BASE = 16'h1E00,
  parameter logic [15:0] COLOUR_BASE = 16'h9600,
  parameter logic [15:0] CHAR_BASE   = 16'h8000,
  parameter int unsigned COLS        = 22,
  parameter int unsigned ROWS        = 23
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [7:0]        fetch_y,
  input  logic              pix_active,
  input  logic [7:0]        pix_x,
  input  logic [3:0]        bg_colour,
  input  logic [3:0]        border_colour,
  vic_line_fetch_if.master  mem,
  output logic [3:0]        pix_colour,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned LINES = ROWS * 8;
  localparam int unsigned WIN_W = COLS * 8;

  typedef enum logic [2:0] {IDLE, A_SCR, A_COL, A_BMP, WR} state_t;

  typedef struct packed {
    logic [2:0] colour;
    logic [7:0] bitmap;
  } entry_t;

  state_t             state_q;
  logic [COL_W-1:0]   col_q;
  logic [7:0]         y_q;
  logic [2:0]         colour_q;
  logic               front_q;
  logic [1:0]         valid_q;
  entry_t             line_buf [2][COLS];

  entry_t             rd_c;
  logic               in_window_c;

  // Character offset within the screen/colour matrices for a given line and column.
  function automatic logic [15:0] char_offset(input logic [7:0] y, input logic [COL_W-1:0] col);
    return 16'(16'(y[7:3]) * 16'(COLS)) + 16'(col);
  endfunction

  // Fetch sequencer. mem_addr is registered, so each state shows the address
  // chosen on the edge that entered it; data for it arrives in the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      front_q      <= 1'b0;
      valid_q      <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      mem.mem_addr <= '0;
    end else if (line_start) begin
      // Swap banks; the new back bank (old front) is invalid until refilled.
      front_q          <= ~front_q;
      valid_q[front_q] <= 1'b0;
      col_q            <= '0;
      if (busy) overrun <= 1'b1;
      if (fetch_y < 8'(LINES)) begin
        y_q          <= fetch_y;
        state_q      <= A_SCR;
        busy         <= 1'b1;
        mem.mem_addr <= SCREEN_BASE + char_offset(fetch_y, '0);
      end else begin
        state_q <= IDLE;
        busy    <= 1'b0;
      end
    end else begin
      case (state_q)
        A_SCR: begin
          mem.mem_addr <= COLOUR_BASE + char_offset(y_q, col_q);
          state_q      <= A_COL;
        end
        A_COL: begin
          // Screen code is on mem_data now; glyph address is built from it directly.
          mem.mem_addr <= CHAR_BASE + {5'b0, mem.mem_data, 3'b000} + {13'b0, y_q[2:0]};
          state_q      <= A_BMP;
        end
        A_BMP: begin
          colour_q <= mem.mem_data[2:0];
          state_q  <= WR;
        end
        WR: begin
          if (col_q == COL_W'(COLS - 1)) begin
            valid_q[~front_q] <= 1'b1;
            busy              <= 1'b0;
            state_q           <= IDLE;
          end else begin
            col_q        <= COL_W'(col_q + 1'b1);
            mem.mem_addr <= SCREEN_BASE + char_offset(y_q, COL_W'(col_q + 1'b1));
            state_q      <= A_SCR;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line buffer write port: glyph byte is on mem_data during WR.
  always_ff @(posedge clk) begin
    if (state_q == WR && !line_start)
      line_buf[~front_q][col_q] <= {colour_q, mem.mem_data};
  end

  // Front-bank read for the display path.
  always_comb begin
    rd_c        = '0;
    in_window_c = pix_active && (pix_x < 8'(WIN_W)) && valid_q[front_q];
    if (pix_x < 8'(WIN_W))
      rd_c = line_buf[front_q][COL_W'(pix_x[7:3])];
  end

  // Registered pixel colour; bit 7 of the glyph byte is the leftmost pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pix_colour <= '0;
    else if (!in_window_c)
      pix_colour <= border_colour;
    else if (rd_c.bitmap[~pix_x[2:0]])
      pix_colour <= {1'b0, rd_c.colour};
    else
      pix_colour <= bg_colour;
  end

endmodule

// File: tb/tb_vic_line_fetch.sv
module tb_vic_line_fetch;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       line_start;
  logic [7:0] fetch_y;
  logic       pix_active;
  logic [7:0] pix_x;
  logic [3:0] bg_colour;
  logic [3:0] border_colour;
  logic [3:0] pix_colour;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [65536];

  vic_line_fetch_if bus ();

  vic_line_fetch dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .line_start    (line_start),
    .fetch_y       (fetch_y),
    .pix_active    (pix_active),
    .pix_x         (pix_x),
    .bg_colour     (bg_colour),
    .border_colour (border_colour),
    .mem           (bus.master),
    .pix_colour    (pix_colour),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Registered RAM: data appears one cycle after the address.
  always @(posedge clk) bus.mem_data <= ram[bus.mem_addr];

  task automatic pulse_line(input logic [7:0] y);
    @(negedge clk);
    line_start = 1'b1;
    fetch_y    = y;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    pix_active = 1'b1;
    pix_x      = 8'd0;
    pulse_line(8'd0);
    repeat (5) @(negedge clk);
    pulse_line(8'd8);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || overrun !== 1'b1 || pix_colour !== 4'd9) begin
      errors++;
      $display("FAIL reset_pre: busy=%b overrun=%b pix=%0d, required 1 1 9", busy, overrun, pix_colour);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0 || pix_colour !== 4'd0 || bus.mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async: busy=%b overrun=%b pix=%0d addr=%h, required 0 0 0 0000",
               busy, overrun, pix_colour, bus.mem_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pix_colour !== 4'd9 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_invalid_banks: pix=%0d busy=%b, required 9 0", pix_colour, busy);
    end
  endtask

  task automatic test_single_line();
    pix_active = 1'b0;
    pulse_line(8'd0);
    checks++;
    if (bus.mem_addr !== 16'h1E00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_addr_scr: addr=%h busy=%b, required 1e00 1", bus.mem_addr, busy);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 16'h9600) begin
      errors++;
      $display("FAIL single_addr_col: addr=%h, required 9600", bus.mem_addr);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 16'h8008) begin
      errors++;
      $display("FAIL single_addr_bmp: addr=%h, required 8008", bus.mem_addr);
    end
    repeat (85) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_c88: busy=%b, required 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_c89: busy=%b, required 0", busy);
    end
    pulse_line(8'd1);
    pix_active = 1'b1;
    pix_x = 8'd0;
    @(negedge clk);
    checks++;
    if (pix_colour !== 4'd2) begin
      errors++;
      $display("FAIL single_pix_x0: pix=%0d, required 2", pix_colour);
    end
    pix_x = 8'd1;
    @(negedge clk);
    checks++;
    if (pix_colour !== 4'd6) begin
      errors++;
      $display("FAIL single_pix_x1: pix=%0d, required 6", pix_colour);
    end
    pix_x = 8'd7;
    @(negedge clk);
    checks++;
    if (pix_colour !== 4'd2) begin
      errors++;
      $display("FAIL single_pix_x7: pix=%0d, required 2", pix_colour);
    end
    wait_idle("single");
  endtask

  task automatic test_row_addressing();
    pulse_line(8'd9);
    checks++;
    if (bus.mem_addr !== 16'h1E16) begin
      errors++;
      $display("FAIL row_addr_scr: addr=%h, required 1e16", bus.mem_addr);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 16'h9616) begin
      errors++;
      $display("FAIL row_addr_col: addr=%h, required 9616", bus.mem_addr);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 16'h8019) begin
      errors++;
      $display("FAIL row_addr_bmp: addr=%h, required 8019", bus.mem_addr);
    end
    wait_idle("row");
    repeat (3) @(negedge clk);
    checks++;
    if (bus.mem_addr !== 16'h8001) begin
      errors++;
      $display("FAIL row_addr_hold: addr=%h, required 8001", bus.mem_addr);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] xs [4] = '{8'd0, 8'd7, 8'd100, 8'd175};
    pix_active = 1'b0;
    pulse_line(8'd184);
    checks++;
    if (busy !== 1'b0 || bus.mem_addr !== 16'h8001) begin
      errors++;
      $display("FAIL oor_start: busy=%b addr=%h, required 0 8001", busy, bus.mem_addr);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.mem_addr !== 16'h8001) begin
      errors++;
      $display("FAIL oor_idle: busy=%b addr=%h, required 0 8001", busy, bus.mem_addr);
    end
    pulse_line(8'd0);
    pix_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix_x = xs[i];
      @(negedge clk);
      checks++;
      if (pix_colour !== 4'd9) begin
        errors++;
        $display("FAIL oor_border_x%0d: pix=%0d, required 9", xs[i], pix_colour);
      end
    end
    wait_idle("oor");
  endtask

  task automatic test_overrun();
    pix_active = 1'b0;
    pulse_line(8'd0);
    repeat (39) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_pre: busy=%b overrun=%b, required 1 0", busy, overrun);
    end
    pulse_line(8'd8);
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1 || bus.mem_addr !== 16'h1E16) begin
      errors++;
      $display("FAIL ovr_restart: overrun=%b busy=%b addr=%h, required 1 1 1e16",
               overrun, busy, bus.mem_addr);
    end
    pix_active = 1'b1;
    pix_x = 8'd0;
    @(negedge clk);
    checks++;
    if (pix_colour !== 4'd9) begin
      errors++;
      $display("FAIL ovr_aborted_bank: pix=%0d, required 9", pix_colour);
    end
    wait_idle("ovr");
    pulse_line(8'd0);
    @(negedge clk);
    checks++;
    if (pix_colour !== 4'd6 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_refetched_bank: pix=%0d overrun=%b, required 6 1", pix_colour, overrun);
    end
    wait_idle("ovr2");
  endtask

  task automatic test_window_edges();
    pix_active = 1'b0;
    pulse_line(8'd0);
    wait_idle("win");
    pulse_line(8'd0);
    pix_active = 1'b1;
    pix_x = 8'd175;
    @(negedge clk);
    checks++;
    if (pix_colour !== 4'd4) begin
      errors++;
      $display("FAIL win_x175: pix=%0d, required 4", pix_colour);
    end
    pix_x = 8'd174;
    @(negedge clk);
    checks++;
    if (pix_colour !== 4'd6) begin
      errors++;
      $display("FAIL win_x174: pix=%0d, required 6", pix_colour);
    end
    pix_x = 8'd176;
    #1;
    checks++;
    if (pix_colour !== 4'd6) begin
      errors++;
      $display("FAIL win_latency: pix=%0d, required 6", pix_colour);
    end
    @(negedge clk);
    checks++;
    if (pix_colour !== 4'd9) begin
      errors++;
      $display("FAIL win_x176: pix=%0d, required 9", pix_colour);
    end
    pix_x = 8'd175;
    pix_active = 1'b0;
    @(negedge clk);
    checks++;
    if (pix_colour !== 4'd9) begin
      errors++;
      $display("FAIL win_inactive: pix=%0d, required 9", pix_colour);
    end
    pix_active = 1'b1;
    @(negedge clk);
    checks++;
    if (pix_colour !== 4'd4) begin
      errors++;
      $display("FAIL win_reactive: pix=%0d, required 4", pix_colour);
    end
    wait_idle("win2");
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
    ram[16'h1E00] = 8'h01;
    ram[16'h9600] = 8'h0A;
    ram[16'h8008] = 8'h81;
    ram[16'h1E15] = 8'h02;
    ram[16'h9615] = 8'h0C;
    ram[16'h8010] = 8'h01;
    ram[16'h1E16] = 8'h03;
    reset_n       = 1'b0;
    line_start    = 1'b0;
    fetch_y       = 8'd0;
    pix_active    = 1'b0;
    pix_x         = 8'd0;
    bg_colour     = 4'd6;
    border_colour = 4'd9;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0 || pix_colour !== 4'd0 || bus.mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_init: busy=%b overrun=%b pix=%0d addr=%h, required 0 0 0 0000",
               busy, overrun, pix_colour, bus.mem_addr);
    end
    reset_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_single_line();
    test_row_addressing();
    test_out_of_range();
    test_overrun();
    test_window_edges();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
